// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing path.
//   - vga_state_t : scan sequencer states (IDLE / RUN / DRAIN)
//   - VGA_*       : 640x480@60 default timing constants
//   - COORD_W     : width of the x/y coordinate buses
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (horizontal or vertical).
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : advance by one position (wraps TOT-1 -> 0)
//   clear      : hold the axis at position 0 (overrides step)
//   count      : current position, registered
//   wrap       : count is at the last position (TOT-1); combinational
//   sync_n     : active-low sync, low for SYNC_START <= count < SYNC_END
//   vis        : high for count < VIS
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOT        = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int VIS        = 640
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               clear,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               sync_n,
    output logic               vis
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOT - 1);
    localparam logic [COORD_W-1:0] SS   = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SE   = COORD_W'(SYNC_END);
    localparam logic [COORD_W-1:0] VL   = COORD_W'(VIS);

    logic [COORD_W-1:0] count_d;

    assign wrap = (count == LAST);

    always_comb begin
        count_d = count;
        if (clear)
            count_d = '0;
        else if (step)
            count_d = wrap ? '0 : count + 1'b1;
    end

    // sync_n and vis are decoded from the next count, so they change on the
    // same edge as count and always describe the position being shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            sync_n <= 1'b1;
            vis    <= 1'b1;
        end else begin
            count  <= count_d;
            sync_n <= !((count_d >= SS) && (count_d < SE));
            vis    <= (count_d < VL);
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA frame sequencer.
//   clk, rst_n   : 100 MHz clock, asynchronous active-low reset
//   pix_tick     : one-clk pulse per pixel period
//   en           : level request to scan; start/stop only at frame boundary
//   hsync, vsync : active-low syncs
//   video_on     : (x,y) inside the visible area while scanning
//   x, y         : current pixel position
//   line_start   : one-clk pulse after x wraps to 0
//   frame_start  : one-clk pulse after (x,y) becomes (0,0) while running
//   busy         : high in RUN and DRAIN
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_tick,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               busy
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
        $error("vga_timing_ctrl: H_TOT/V_TOT must not exceed 1024");
    end

    vga_state_t state, state_d;
    logic       h_step, v_step, h_wrap, v_wrap, frame_wrap, clear;
    logic       h_vis, v_vis, fs_d;

    assign clear      = (state == IDLE);
    assign h_step     = (state != IDLE) && pix_tick;
    assign v_step     = h_step && h_wrap;
    assign frame_wrap = v_step && v_wrap;

    vga_axis_counter #(
        .TOT        (H_TOT),
        .SYNC_START (H_VIS + H_FP),
        .SYNC_END   (H_VIS + H_FP + H_SYNC),
        .VIS        (H_VIS)
    ) u_h (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (h_step),
        .clear  (clear),
        .count  (x),
        .wrap   (h_wrap),
        .sync_n (hsync),
        .vis    (h_vis)
    );

    vga_axis_counter #(
        .TOT        (V_TOT),
        .SYNC_START (V_VIS + V_FP),
        .SYNC_END   (V_VIS + V_FP + V_SYNC),
        .VIS        (V_VIS)
    ) u_v (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (v_step),
        .clear  (clear),
        .count  (y),
        .wrap   (v_wrap),
        .sync_n (vsync),
        .vis    (v_vis)
    );

    // DRAIN with en back high resumes RUN; a wrap on that same tick is a
    // normal RUN wrap and pulses frame_start.
    always_comb begin
        state_d = state;
        fs_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pix_tick && en) begin
                    state_d = RUN;
                    fs_d    = 1'b1;
                end
            end
            RUN: begin
                fs_d = frame_wrap;
                if (!en)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                    fs_d    = frame_wrap;
                end else if (frame_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            busy        <= (state_d != IDLE);
            line_start  <= v_step;
            frame_start <= fs_d;
        end
    end

    // All three terms are flop outputs updated on the same edge.
    assign video_on = h_vis && v_vis && busy;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

    // Reduced-timing instance used for whole-frame behaviour.
    localparam int SH_VIS = 16, SH_FP = 4, SH_SYNC = 6, SH_BP = 4;
    localparam int SV_VIS = 12, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
    localparam int STOT  = SH_VIS + SH_FP + SH_SYNC + SH_BP;   // 30
    localparam int SVTOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;   // 19
    localparam int SFRM  = STOT * SVTOT;                       // 570

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_tick = 1'b0;
    logic en = 1'b0;

    logic       hs, vs, von, ls, fs, busy;
    logic [9:0] x, y;
    logic       s_hs, s_vs, s_von, s_ls, s_fs, s_busy;
    logic [9:0] s_x, s_y;

    int npass = 0;
    int ntotal = 0;
    int gap = 3;
    logic mon = 1'b0;
    logic busy_drop = 1'b0;

    always #5 clk = ~clk;

    vga_timing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .en(en),
        .hsync(hs), .vsync(vs), .video_on(von), .x(x), .y(y),
        .line_start(ls), .frame_start(fs), .busy(busy)
    );

    vga_timing_ctrl #(
        .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .en(en),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .busy(s_busy)
    );

    always @(negedge clk)
        if (mon && !s_busy) busy_drop = 1'b1;

    typedef struct {
        int adv;
        int ex, ey, ehs, evs, evon, els;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // gap idle clks, then one tick; sample 1 time unit after the tick edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            pix_tick = 1'b1;
            @(posedge clk); #1;
            pix_tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; pix_tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int von_cnt, ls_cnt, vs_lo, vmin, vmax, flen, t0, per;
        bit found;

        tbl[0] = '{639, 639, 0, 1, 1, 1, 0};
        tbl[1] = '{1,   640, 0, 1, 1, 0, 0};
        tbl[2] = '{16,  656, 0, 0, 1, 0, 0};
        tbl[3] = '{95,  751, 0, 0, 1, 0, 0};
        tbl[4] = '{1,   752, 0, 1, 1, 0, 0};
        tbl[5] = '{47,  799, 0, 1, 1, 0, 0};
        tbl[6] = '{1,   0,   1, 1, 1, 1, 1};
        tbl[7] = '{1,   1,   1, 1, 1, 1, 0};

        // ---------------- reset values
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_hsync", hs, 1);  chk("rst_vsync", vs, 1);
        chk("rst_video_on", von, 0);
        chk("rst_x", x, 0);       chk("rst_y", y, 0);
        chk("rst_line_start", ls, 0); chk("rst_frame_start", fs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_busy", s_busy, 0); chk("rst_s_x", s_x, 0);

        // ---------------- start, tick every 4th clk
        en = 1'b1;
        gap = 3;
        tick(1);
        chk("start_frame_start", fs, 1); chk("start_busy", busy, 1);
        chk("start_x", x, 0);  chk("start_y", y, 0);
        chk("start_video_on", von, 1);
        chk("start_s_frame_start", s_fs, 1);

        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].adv);
            chk($sformatf("tbl%0d_x", i), x, tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), y, tbl[i].ey);
            chk($sformatf("tbl%0d_hsync", i), hs, tbl[i].ehs);
            chk($sformatf("tbl%0d_vsync", i), vs, tbl[i].evs);
            chk($sformatf("tbl%0d_video_on", i), von, tbl[i].evon);
            chk($sformatf("tbl%0d_line_start", i), ls, tbl[i].els);
        end

        // ---------------- continuous pix_tick: full small frame, default line period
        do_reset();
        en = 1'b1; pix_tick = 1'b1;
        @(posedge clk); #1;
        chk("cont_s_frame_start", s_fs, 1);
        von_cnt = s_von ? 1 : 0;
        ls_cnt = 0; vs_lo = 0; vmin = 1023; vmax = 0; flen = 0; found = 0;
        for (int k = 1; k < 2000; k++) begin
            @(posedge clk); #1;
            if (k <= 4) chk($sformatf("cont_x_%0d", k), x, k);
            if (s_ls) ls_cnt++;
            if (s_fs) begin
                found = 1; flen = k;
                break;
            end
            if (s_von) von_cnt++;
            if (!s_vs) begin
                vs_lo++;
                if (s_y < vmin) vmin = s_y;
                if (s_y > vmax) vmax = s_y;
            end
        end
        chk("frame_found", found, 1);
        chk("frame_len", flen, SFRM);
        chk("frame_line_starts", ls_cnt, SVTOT);
        chk("frame_video_on_ticks", von_cnt, SH_VIS * SV_VIS);
        chk("frame_vsync_low_ticks", vs_lo, SV_SYNC * STOT);
        chk("frame_vsync_ymin", vmin, SV_VIS + SV_FP);
        chk("frame_vsync_ymax", vmax, SV_VIS + SV_FP + SV_SYNC - 1);

        found = 0; t0 = 0;
        for (int k = 0; k < 2000; k++) begin
            if (ls) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("cont_ls_found", found, 1);
        chk("cont_ls_y", y, 1);
        found = 0; per = 0;
        for (int k = 1; k < 2000; k++) begin
            @(posedge clk); #1;
            if (ls) begin found = 1; per = k; break; end
        end
        chk("cont_ls_period", per, 800);
        pix_tick = 1'b0;

        // ---------------- drain from y=3
        gap = 1;
        do_reset();
        en = 1'b1;
        tick(1);
        tick(3 * STOT);
        en = 1'b0;
        @(posedge clk); #1;
        chk("drain_busy", s_busy, 1);
        chk("drain_hold_x", s_x, 0); chk("drain_hold_y", s_y, 3);
        tick(SFRM - 1 - 3 * STOT);
        chk("drain_last_x", s_x, STOT - 1); chk("drain_last_y", s_y, SVTOT - 1);
        chk("drain_last_busy", s_busy, 1);
        tick(1);
        chk("drain_end_busy", s_busy, 0); chk("drain_end_frame_start", s_fs, 0);
        chk("drain_end_x", s_x, 0); chk("drain_end_y", s_y, 0);
        chk("drain_end_hsync", s_hs, 1); chk("drain_end_vsync", s_vs, 1);
        tick(3);
        chk("idle_hold_x", s_x, 0); chk("idle_hold_busy", s_busy, 0);
        chk("idle_hold_frame_start", s_fs, 0);

        // ---------------- en 1->0->1 inside DRAIN at y=8
        do_reset();
        en = 1'b1;
        tick(1);
        tick(8 * STOT);
        mon = 1'b1;
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
        chk("toggle_x", s_x, 0); chk("toggle_y", s_y, 8);
        tick(SFRM - 1 - 8 * STOT);
        chk("toggle_pre_x", s_x, STOT - 1); chk("toggle_pre_y", s_y, SVTOT - 1);
        tick(1);
        chk("toggle_wrap_frame_start", s_fs, 1);
        chk("toggle_wrap_line_start", s_ls, 1);
        chk("toggle_wrap_x", s_x, 0); chk("toggle_wrap_y", s_y, 0);
        mon = 1'b0;
        chk("toggle_busy_never_dropped", busy_drop, 0);

        // ---------------- en falls on the wrap tick in RUN
        tick(SFRM - 1);
        gap = 0;
        en = 1'b0;
        tick(1);
        gap = 1;
        chk("simul_frame_start", s_fs, 1); chk("simul_busy", s_busy, 1);
        chk("simul_x", s_x, 0); chk("simul_y", s_y, 0);
        tick(SFRM - 1);
        chk("simul_last_busy", s_busy, 1); chk("simul_last_y", s_y, SVTOT - 1);
        tick(1);
        chk("simul_end_busy", s_busy, 0); chk("simul_end_frame_start", s_fs, 0);

        // ---------------- async reset mid-frame with both syncs low
        do_reset();
        en = 1'b1;
        tick(1);
        tick(15 * STOT + 22);
        chk("pre_rst_hsync", s_hs, 0); chk("pre_rst_vsync", s_vs, 0);
        chk("pre_rst_x", s_x, 22);     chk("pre_rst_y", s_y, 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hsync", s_hs, 1); chk("arst_vsync", s_vs, 1);
        chk("arst_x", s_x, 0);      chk("arst_y", s_y, 0);
        chk("arst_busy", s_busy, 0); chk("arst_video_on", s_von, 0);
        chk("arst_dflt_x", x, 0);
        #2;
        rst_n = 1'b1;
        en = 1'b0;
        @(posedge clk); #1;
        tick(3);
        chk("post_rst_idle_busy", s_busy, 0); chk("post_rst_idle_x", s_x, 0);
        en = 1'b1;
        tick(1);
        chk("post_rst_frame_start", s_fs, 1); chk("post_rst_busy", s_busy, 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
